// File: rtl/pressure_alarm_if.sv
// ---------------------------------------------------------------------------
// pressure_alarm_if
// Bundles the sample/acknowledge inputs and the alarm status outputs of the
// pressure alarm controller.
//   sampleValid          qualifies pressureAbnormality for the current cycle
//   pressureAbnormality  detector flag, 1 = abnormal
//   alarmAck             operator acknowledge (level)
//   alarmActive          1 while an alarm is raised or acknowledged
//   alarmLed             blinking / steady alarm indicator
//   alarmState           NORMAL=00, SUSPECT=01, ALARM=10, ACKED=11
//   eventCount           saturating count of confirmed alarms
// master: the side that produces samples and acknowledges (system / bench)
// slave : the alarm controller itself
// ---------------------------------------------------------------------------
interface pressure_alarm_if #(
  parameter int EVT_W = 8
);
  logic             sampleValid;
  logic             pressureAbnormality;
  logic             alarmAck;
  logic             alarmActive;
  logic             alarmLed;
  logic [1:0]       alarmState;
  logic [EVT_W-1:0] eventCount;

  modport master (
    output sampleValid,
    output pressureAbnormality,
    output alarmAck,
    input  alarmActive,
    input  alarmLed,
    input  alarmState,
    input  eventCount
  );

  modport slave (
    input  sampleValid,
    input  pressureAbnormality,
    input  alarmAck,
    output alarmActive,
    output alarmLed,
    output alarmState,
    output eventCount
  );
endinterface

// File: rtl/pressure_alarm_controller.sv
// ---------------------------------------------------------------------------
// pressure_alarm_controller
// Filters the pressure detector's abnormality flag over consecutive valid
// samples, raises a latched alarm, blinks an alarm LED until the operator
// acknowledges, then waits for a run of normal samples before clearing.
// Confirmed alarm entries are counted in a saturating event counter.
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous reset, active-high; clears state, counters, outputs
//   bus   pressure_alarm_if.slave (samples/ack in, status out)
// All outputs are registered: they reflect the decision made at the edge
// that sampled the cause.
// ---------------------------------------------------------------------------
module pressure_alarm_controller #(
  parameter int CONFIRM_CNT = 4,
  parameter int CLEAR_CNT   = 4,
  parameter int BLINK_DIV   = 8,
  parameter int EVT_W       = 8
) (
  input  logic            clk,
  input  logic            rst,
  pressure_alarm_if.slave bus
);

  localparam int MAX_CNT = (CONFIRM_CNT > CLEAR_CNT) ? CONFIRM_CNT : CLEAR_CNT;
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;
  localparam int BLK_W   = $clog2(BLINK_DIV) + 1;

  localparam logic [CNT_W-1:0] CONF_LIMIT = CNT_W'(CONFIRM_CNT);
  localparam logic [CNT_W-1:0] CLR_LIMIT  = CNT_W'(CLEAR_CNT);
  localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    NORMAL  = 2'b00,
    SUSPECT = 2'b01,
    ALARM   = 2'b10,
    ACKED   = 2'b11
  } state_t;

  state_t           state,     stateNext;
  logic [CNT_W-1:0] confCnt,   confNext;
  logic [CNT_W-1:0] clrCnt,    clrNext;
  logic [BLK_W-1:0] blinkCnt,  blinkNext;
  logic [EVT_W-1:0] evtCnt,    evtNext;
  logic             ledQ,      ledNext;
  logic             activeQ,   activeNext;
  logic             enterAlarm;
  logic             abn;
  logic             nrm;

  // Event counter holds at all-ones instead of wrapping.
  function automatic logic [EVT_W-1:0] satIncEvt(input logic [EVT_W-1:0] v);
    return (&v) ? v : v + EVT_W'(1);
  endfunction

  // Filter counters never wrap, even if a limit were set at the width ceiling.
  function automatic logic [CNT_W-1:0] satIncCnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign abn = bus.sampleValid &  bus.pressureAbnormality;
  assign nrm = bus.sampleValid & ~bus.pressureAbnormality;

  always_comb begin
    stateNext  = state;
    confNext   = confCnt;
    clrNext    = clrCnt;
    blinkNext  = '0;
    evtNext    = evtCnt;
    ledNext    = 1'b0;
    activeNext = 1'b0;
    enterAlarm = 1'b0;

    case (state)
      NORMAL: begin
        if (abn) begin
          confNext = CNT_W'(1);
          if (CONF_LIMIT <= CNT_W'(1)) begin
            enterAlarm = 1'b1;
          end else begin
            stateNext = SUSPECT;
          end
        end
      end

      SUSPECT: begin
        // The confirming sample takes priority over any ack on the same edge;
        // ack is simply not looked at here.
        if (abn) begin
          confNext = satIncCnt(confCnt);
          if (confNext >= CONF_LIMIT) begin
            enterAlarm = 1'b1;
          end
        end else if (nrm) begin
          stateNext = NORMAL;
          confNext  = '0;
        end
      end

      ALARM: begin
        // Samples cannot clear a raised alarm; only the operator can.
        if (bus.alarmAck) begin
          stateNext = ACKED;
          clrNext   = '0;
        end
      end

      ACKED: begin
        // Any abnormal sample restarts the clear run but never re-raises.
        if (nrm) begin
          clrNext = satIncCnt(clrCnt);
          if (clrNext >= CLR_LIMIT) begin
            stateNext = NORMAL;
            confNext  = '0;
            clrNext   = '0;
          end
        end else if (abn) begin
          clrNext = '0;
        end
      end

      default: begin
        stateNext = NORMAL;
        confNext  = '0;
        clrNext   = '0;
      end
    endcase

    if (enterAlarm) begin
      stateNext = ALARM;
      confNext  = '0;
      evtNext   = satIncEvt(evtCnt);
    end

    // LED: starts lit on alarm entry, toggles every BLINK_DIV cycles while
    // the alarm stays unacknowledged, steady once acknowledged.
    if (enterAlarm) begin
      blinkNext = '0;
      ledNext   = 1'b1;
    end else if (state == ALARM && stateNext == ALARM) begin
      if (blinkCnt >= BLK_LAST) begin
        blinkNext = '0;
        ledNext   = ~ledQ;
      end else begin
        blinkNext = blinkCnt + BLK_W'(1);
        ledNext   = ledQ;
      end
    end else if (stateNext == ACKED) begin
      ledNext = 1'b1;
    end

    activeNext = (stateNext == ALARM) || (stateNext == ACKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= NORMAL;
      confCnt  <= '0;
      clrCnt   <= '0;
      blinkCnt <= '0;
      evtCnt   <= '0;
      ledQ     <= 1'b0;
      activeQ  <= 1'b0;
    end else begin
      state    <= stateNext;
      confCnt  <= confNext;
      clrCnt   <= clrNext;
      blinkCnt <= blinkNext;
      evtCnt   <= evtNext;
      ledQ     <= ledNext;
      activeQ  <= activeNext;
    end
  end

  assign bus.alarmState  = state;
  assign bus.alarmActive = activeQ;
  assign bus.alarmLed    = ledQ;
  assign bus.eventCount  = evtCnt;

endmodule
